// File: rtl/conv_loop_sequencer_pkg.sv
// rtl/conv_loop_sequencer_pkg.sv - shared types and constants for the convolution loop sequencer
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    localparam int CONV_ADDR_W = 8;

    // Number of taps in one full convolution: every output pixel visits every kernel tap.
    function automatic int tap_count(input int out_size, input int k);
        return out_size * out_size * k * k;
    endfunction

endpackage

// File: rtl/conv_loop_sequencer_if.sv
// rtl/conv_loop_sequencer_if.sv - control/BRAM/output-buffer bundle of the convolution loop sequencer
//
// master: the sequencer (drives busy/done, BRAM addresses and enables, MAC control, output strobes)
// slave : the surrounding datapath (drives start and stall)
// pad_zero exists only when CONV_SEQ_ZERO_PAD_EN is defined.
interface conv_loop_sequencer_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = CONV_ADDR_W
);
    logic              start;
    logic              stall;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] weight_addr;
    logic              input_ena;
    logic              weight_ena;
    logic              mac_en;
    logic              acc_clr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_wea;
`ifdef CONV_SEQ_ZERO_PAD_EN
    logic              pad_zero;
`endif

    modport master (
        input  start,
        input  stall,
`ifdef CONV_SEQ_ZERO_PAD_EN
        output pad_zero,
`endif
        output busy,
        output done,
        output ifm_addr,
        output weight_addr,
        output input_ena,
        output weight_ena,
        output mac_en,
        output acc_clr,
        output out_addr,
        output out_wea
    );

    modport slave (
        output start,
        output stall,
`ifdef CONV_SEQ_ZERO_PAD_EN
        input  pad_zero,
`endif
        input  busy,
        input  done,
        input  ifm_addr,
        input  weight_addr,
        input  input_ena,
        input  weight_ena,
        input  mac_en,
        input  acc_clr,
        input  out_addr,
        input  out_wea
    );

endinterface

// File: rtl/conv_loop_sequencer_tap_counter.sv
// rtl/conv_loop_sequencer_tap_counter.sv - cascaded j/i/c/r loop counters for the convolution sequencer
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   advance               step to the next tap this cycle
//   freeze                hold all counters (overrides advance)
//   r, c, i, j            current output row/col and kernel row/col
//   first_kernel_tap      i==0 && j==0
//   last_kernel_tap       i==K-1 && j==K-1
//   last_tap              last kernel tap of the last output pixel
module conv_tap_counter #(
    parameter int OUT_SIZE = 2,
    parameter int K        = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic             freeze,
    output logic [CNT_W-1:0] r,
    output logic [CNT_W-1:0] c,
    output logic [CNT_W-1:0] i,
    output logic [CNT_W-1:0] j,
    output logic             first_kernel_tap,
    output logic             last_kernel_tap,
    output logic             last_tap
);

    logic step;
    logic j_last, i_last, c_last, r_last;

    assign step   = advance & ~freeze;
    assign j_last = (j == CNT_W'(K - 1));
    assign i_last = (i == CNT_W'(K - 1));
    assign c_last = (c == CNT_W'(OUT_SIZE - 1));
    assign r_last = (r == CNT_W'(OUT_SIZE - 1));

    assign first_kernel_tap = (i == '0) && (j == '0);
    assign last_kernel_tap  = i_last && j_last;
    assign last_tap         = last_kernel_tap && c_last && r_last;

    // Stepping past the final tap wraps everything back to zero, so the
    // sequencer is already positioned on tap 0 for the next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r <= '0;
            c <= '0;
            i <= '0;
            j <= '0;
        end else if (step) begin
            if (!j_last) begin
                j <= j + CNT_W'(1);
            end else begin
                j <= '0;
                if (!i_last) begin
                    i <= i + CNT_W'(1);
                end else begin
                    i <= '0;
                    if (!c_last) begin
                        c <= c + CNT_W'(1);
                    end else begin
                        c <= '0;
                        r <= r_last ? '0 : r + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// rtl/conv_loop_sequencer.sv - sequences one single-channel k x k convolution over a BRAM feature map
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   bus (master)     start/stall in; busy/done, ifm/weight BRAM addresses and enables,
//                    mac_en/acc_clr MAC control, out_addr/out_wea output-buffer strobes
// Optional feature: define CONV_SEQ_ZERO_PAD_EN to honour 'padding' and add bus.pad_zero.
//
// Pipeline: the tap stage (counters + enables) is followed by one BRAM read stage
// (mac_en/acc_clr) and one output-write stage (out_wea/out_addr). stall freezes all of it.
module conv_loop_sequencer
    import conv_pkg::*;
#(
    parameter int in_size  = 4,
    parameter int out_size = 2,
    parameter int k        = 3,
    parameter int stride   = 1,
    parameter int padding  = 0,
    parameter int ADDR_W   = CONV_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    conv_loop_sequencer_if.master bus
);

`ifdef CONV_SEQ_ZERO_PAD_EN
    localparam int PAD_EFF = padding;
`else
    // Without zero-pad support the border width has no meaning.
    localparam int PAD_EFF = 0 * padding;
`endif

    conv_state_e state, state_n;

    logic [ADDR_W-1:0] r, c, i, j;
    logic              first_kernel_tap, last_kernel_tap, last_tap;
    logic              issue;
    logic              stall;

    int                y_c, x_c;
    logic [ADDR_W-1:0] ifm_addr_c, weight_addr_c, pix_addr_c;

    // Read stage (one cycle behind the tap stage)
    logic              mac_q, clr_q, last_q;
    logic [ADDR_W-1:0] pix_q;
    // Write stage
    logic              wea_q;
    logic [ADDR_W-1:0] out_addr_q;

`ifdef CONV_SEQ_ZERO_PAD_EN
    logic              pad_c;
    logic              pad_q;
`endif

    assign stall = bus.stall;
    assign issue = (state == RUN);

    conv_tap_counter #(
        .OUT_SIZE (out_size),
        .K        (k),
        .CNT_W    (ADDR_W)
    ) u_tap_counter (
        .clock            (clock),
        .reset            (reset),
        .advance          (issue),
        .freeze           (stall),
        .r                (r),
        .c                (c),
        .i                (i),
        .j                (j),
        .first_kernel_tap (first_kernel_tap),
        .last_kernel_tap  (last_kernel_tap),
        .last_tap         (last_tap)
    );

    // Address arithmetic on the current tap; signed so padded coordinates can go negative.
    always_comb begin
        y_c           = int'(r) * stride + int'(i) - PAD_EFF;
        x_c           = int'(c) * stride + int'(j) - PAD_EFF;
        ifm_addr_c    = ADDR_W'(y_c * in_size + x_c);
        weight_addr_c = ADDR_W'(int'(i) * k + int'(j));
        pix_addr_c    = ADDR_W'(int'(r) * out_size + int'(c));
`ifdef CONV_SEQ_ZERO_PAD_EN
        pad_c = (y_c < 0) || (y_c >= in_size) || (x_c < 0) || (x_c >= in_size);
        if (pad_c) begin
            ifm_addr_c = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (!stall && last_tap) state_n = DRAIN;
            // Done once the final pixel's write is out and nothing is left in the read stage.
            DRAIN:   if (!stall && wea_q && !mac_q) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mac_q      <= 1'b0;
            clr_q      <= 1'b0;
            last_q     <= 1'b0;
            pix_q      <= '0;
            wea_q      <= 1'b0;
            out_addr_q <= '0;
`ifdef CONV_SEQ_ZERO_PAD_EN
            pad_q      <= 1'b0;
`endif
        end else if (!stall) begin
            mac_q  <= issue;
            clr_q  <= issue & first_kernel_tap;
            last_q <= issue & last_kernel_tap;
            pix_q  <= pix_addr_c;
            wea_q  <= mac_q & last_q;
            if (mac_q && last_q) begin
                out_addr_q <= pix_q;
            end
`ifdef CONV_SEQ_ZERO_PAD_EN
            pad_q  <= issue & pad_c;
`endif
        end
    end

    assign bus.busy        = (state == RUN) || (state == DRAIN);
    assign bus.done        = (state == DONE);
    assign bus.ifm_addr    = ifm_addr_c;
    assign bus.weight_addr = weight_addr_c;
    assign bus.weight_ena  = issue & ~stall;
`ifdef CONV_SEQ_ZERO_PAD_EN
    assign bus.input_ena   = issue & ~stall & ~pad_c;
    assign bus.pad_zero    = pad_q & ~stall;
`else
    assign bus.input_ena   = issue & ~stall;
`endif
    assign bus.mac_en      = mac_q & ~stall;
    assign bus.acc_clr     = clr_q & ~stall;
    assign bus.out_wea     = wea_q & ~stall;
    assign bus.out_addr    = out_addr_q;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// tb/tb_conv_loop_sequencer.sv - scoreboard bench for conv_loop_sequencer
module tb_conv_loop_sequencer;
    import conv_pkg::*;

    localparam int IN_SIZE  = 4;
    localparam int OUT_SIZE = 2;
    localparam int K        = 3;
    localparam int STRIDE   = 1;
    localparam int AW       = 8;
    localparam int TAPS     = 36;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    conv_loop_sequencer_if #(.ADDR_W(AW)) bus ();

    conv_loop_sequencer #(
        .in_size  (IN_SIZE),
        .out_size (OUT_SIZE),
        .k        (K),
        .stride   (STRIDE),
        .padding  (0),
        .ADDR_W   (AW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic [15:0] tap_exp_q[$];
    bit          clr_exp_q[$];
    logic [7:0]  wea_exp_q[$];
    int          done_exp_q[$];

    int n_ena = 0, n_mac = 0, n_clr = 0, n_wea = 0, n_done = 0, issue_idx = 0;
    logic [7:0] obs_ifm [0:511];
    logic [7:0] obs_w   [0:511];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents an event.
    always @(negedge clock) begin
        if (reset) begin
            tap_exp_q.delete();
            clr_exp_q.delete();
            wea_exp_q.delete();
            done_exp_q.delete();
        end else begin
            if (bus.stall) begin
                check("stall_gate",
                      int'({bus.input_ena, bus.weight_ena, bus.mac_en, bus.acc_clr, bus.out_wea}), 0);
            end
            if (bus.input_ena) begin
                logic [15:0] e;
                n_ena++;
                if (issue_idx < 512) begin
                    obs_ifm[issue_idx] = bus.ifm_addr;
                    obs_w[issue_idx]   = bus.weight_addr;
                end
                issue_idx++;
                check("weight_ena_with_input_ena", int'(bus.weight_ena), 1);
                check("busy_during_tap", int'(bus.busy), 1);
                if (tap_exp_q.size() == 0) begin
                    check("unexpected_tap", 1, 0);
                end else begin
                    e = tap_exp_q.pop_front();
                    check("ifm_addr", int'(bus.ifm_addr), int'(e[15:8]));
                    check("weight_addr", int'(bus.weight_addr), int'(e[7:0]));
                end
            end
            if (bus.mac_en) begin
                n_mac++;
                if (bus.acc_clr) n_clr++;
                if (clr_exp_q.size() == 0) check("unexpected_mac_en", 1, 0);
                else check("acc_clr", int'(bus.acc_clr), int'(clr_exp_q.pop_front()));
            end else if (bus.acc_clr) begin
                check("acc_clr_without_mac_en", 1, 0);
            end
            if (bus.out_wea) begin
                n_wea++;
                if (wea_exp_q.size() == 0) check("unexpected_out_wea", 1, 0);
                else check("out_addr", int'(bus.out_addr), int'(wea_exp_q.pop_front()));
            end
            if (bus.done) begin
                n_done++;
                check("busy_low_at_done", int'(bus.busy), 0);
                if (done_exp_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_cycle", cyc, done_exp_q.pop_front());
            end
        end
    end

    task automatic push_run(input int n0, input int extra);
        for (int r = 0; r < OUT_SIZE; r++) begin
            for (int c = 0; c < OUT_SIZE; c++) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        tap_exp_q.push_back({8'((r * STRIDE + i) * IN_SIZE + c * STRIDE + j),
                                             8'(i * K + j)});
                        clr_exp_q.push_back(i == 0 && j == 0);
                    end
                end
                wea_exp_q.push_back(8'(r * OUT_SIZE + c));
            end
        end
        done_exp_q.push_back(n0 + tap_count(OUT_SIZE, K) + 2 + extra);
    endtask

    task automatic pulse_start(output int n0);
        @(posedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        n0 = cyc;
    endtask

    task automatic wait_done(input int target);
        int w;
        w = 0;
        while (n_done < target && w < 200) begin
            @(posedge clock);
            w++;
        end
        if (n_done < target) check("done_timeout", 0, 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_run(input string tag, input int b_ena, input int b_mac, input int b_clr,
                             input int b_wea, input int runs);
        check({tag, "_input_ena_count"}, n_ena - b_ena, runs * TAPS);
        check({tag, "_mac_en_count"}, n_mac - b_mac, runs * TAPS);
        check({tag, "_acc_clr_count"}, n_clr - b_clr, runs * OUT_SIZE * OUT_SIZE);
        check({tag, "_out_wea_count"}, n_wea - b_wea, runs * OUT_SIZE * OUT_SIZE);
        check({tag, "_queues_drained"},
              tap_exp_q.size() + clr_exp_q.size() + wea_exp_q.size() + done_exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_ifm_addr"}, int'(bus.ifm_addr), 0);
        check({tag, "_weight_addr"}, int'(bus.weight_addr), 0);
        check({tag, "_enables"},
              int'({bus.input_ena, bus.weight_ena, bus.mac_en, bus.acc_clr, bus.out_wea}), 0);
        check({tag, "_out_addr"}, int'(bus.out_addr), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, n1, be, bm, bc, bw, bi, bd;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Plain run with tap spot checks
        be = n_ena; bm = n_mac; bc = n_clr; bw = n_wea; bi = issue_idx;
        pulse_start(n0);
        push_run(n0, 0);
        wait_done(1);
        check_run("run1", be, bm, bc, bw, 1);
        check("tap_r1c1i2j2_ifm", int'(obs_ifm[bi + 35]), 15);
        check("tap_r1c1i2j2_w", int'(obs_w[bi + 35]), 8);
        check("tap_r0c1i1j0_ifm", int'(obs_ifm[bi + 12]), 5);
        check("tap_r0c1i1j0_w", int'(obs_w[bi + 12]), 3);

        // Five-cycle stall at tap 10
        be = n_ena; bm = n_mac; bc = n_clr; bw = n_wea;
        pulse_start(n0);
        push_run(n0, 5);
        repeat (9) @(posedge clock);
        #1;
        bus.stall = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        bus.stall = 1'b0;
        wait_done(2);
        check_run("stall", be, bm, bc, bw, 1);

        // Starts during RUN and during DONE are ignored; start in next IDLE is taken
        be = n_ena; bm = n_mac; bc = n_clr; bw = n_wea; bd = n_done;
        pulse_start(n0);
        push_run(n0, 0);
        repeat (4) @(posedge clock);
        #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        while (cyc < n0 + TAPS + 2) begin
            @(posedge clock); #1;
        end
        check("done_high_when_start_in_done", int'(bus.done), 1);
        bus.start = 1'b1;
        @(posedge clock); #1;
        check("idle_after_done", int'(bus.busy), 0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        n1 = cyc;
        push_run(n1, 0);
        wait_done(bd + 2);
        check_run("restart", be, bm, bc, bw, 2);
        check("restart_done_count", n_done - bd, 2);

        // Reset mid-run at tap 20, then a full run from tap 0
        pulse_start(n0);
        push_run(n0, 0);
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        be = n_ena; bm = n_mac; bc = n_clr; bw = n_wea; bi = issue_idx; bd = n_done;
        pulse_start(n0);
        push_run(n0, 0);
        wait_done(bd + 1);
        check_run("after_abort", be, bm, bc, bw, 1);
        check("after_abort_first_ifm", int'(obs_ifm[bi]), 0);
        check("after_abort_last_ifm", int'(obs_ifm[bi + 35]), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
